button_event_scheduler: RTL

//  Debounces N raw push-buttons and serialises their press events onto one valid/ready stream.
//  - Shared sample-tick prescaler; per-button stable counters.
//  - Round-robin arbiter queues at most one pending press per button.
//  - Sits between board button pins and the control logic that consumes user commands.

---
 rtl/button_event_scheduler.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/button_event_scheduler.sv
// button_event_scheduler
//   Debounces N_BTN raw push-buttons and serialises their press events onto a
//   single valid/ready stream. A shared prescaler produces one sample tick every
//   TICK_DIV clocks. Each button has its own stable counter, and a round-robin
//   arbiter drains the per-button pending bits into a registered output slot.
//
//   Optional feature: define LONGPRESS_EN to add per-button hold counters that
//   raise a second (long-press) event after LONG_TICKS ticks held. When it is
//   undefined, evt_long is tied to 0.
//
// Ports
//   clk        in   system clock
//   rst        in   asynchronous reset, active-high
//   btn_in     in   raw asynchronous button levels (1 = pressed)
//   btn_state  out  debounced button levels
//   evt_valid  out  event available in the output slot
//   evt_ready  in   consumer accepts the event when evt_valid && evt_ready
//   evt_id     out  index of the button that produced the event
//   evt_long   out  1 = long-press event, 0 = press event
//   overrun    out  one-cycle pulse: press dropped because one was already pending
module button_event_scheduler #(
  parameter int N_BTN         = 4,
  parameter int TICK_DIV      = 1000,
  parameter int DEBOUNCE_WAIT = 8,
  parameter int LONG_TICKS    = 500,
  localparam int IW           = (N_BTN > 1) ? $clog2(N_BTN) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IW-1:0]    evt_id,
  output logic             evt_long,
  output logic             overrun
);

  localparam int PW = $clog2(TICK_DIV);
  localparam int CW = $clog2(DEBOUNCE_WAIT + 1);

  logic [N_BTN-1:0] sync1_q, sync2_q;
  logic [PW-1:0]    presc_q;
  logic             tick;

  logic [CW-1:0]    cnt_q [N_BTN];
  logic [CW-1:0]    cnt_d [N_BTN];
  logic [N_BTN-1:0] state_q, state_d;
  logic [N_BTN-1:0] rise;

  logic [N_BTN-1:0] pend_q, pend_d, clr_press;
  logic [N_BTN-1:0] req;
  logic             found;
  logic [IW-1:0]    gnt, cand;

  logic             valid_q, valid_d;
  logic [IW-1:0]    id_q, id_d;
  logic [IW-1:0]    last_q, last_d;
  logic             overrun_q, overrun_d;

  // Synchroniser and sample-tick prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      presc_q <= '0;
    end else begin
      sync1_q <= btn_in;
      sync2_q <= sync1_q;
      presc_q <= tick ? '0 : presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PW'(TICK_DIV - 1));

  // Debounce: a level flips only after DEBOUNCE_WAIT consecutive disagreeing ticks
  always_comb begin
    state_d = state_q;
    rise    = '0;
    for (int i = 0; i < N_BTN; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (sync2_q[i] != state_q[i]) begin
          if (cnt_q[i] == CW'(DEBOUNCE_WAIT - 1)) begin
            state_d[i] = ~state_q[i];
            cnt_d[i]   = '0;
            rise[i]    = ~state_q[i];
          end else begin
            cnt_d[i] = cnt_q[i] + 1'b1;
          end
        end else begin
          cnt_d[i] = '0;
        end
      end
    end
  end

`ifdef LONGPRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);

  logic [HW-1:0]    hold_q [N_BTN];
  logic [HW-1:0]    hold_d [N_BTN];
  logic [N_BTN-1:0] long_rise;
  logic [N_BTN-1:0] pend_long_q, pend_long_d, clr_long;
  logic             long_q, long_d;

  // Hold counter saturates at LONG_TICKS, so the long event fires once per press
  always_comb begin
    long_rise = '0;
    for (int i = 0; i < N_BTN; i++) begin
      hold_d[i] = hold_q[i];
      if (!state_q[i]) begin
        hold_d[i] = '0;
      end else if (tick && (hold_q[i] != HW'(LONG_TICKS))) begin
        hold_d[i] = hold_q[i] + 1'b1;
        if (hold_q[i] == HW'(LONG_TICKS - 1)) long_rise[i] = 1'b1;
      end
    end
  end

  assign req         = pend_q | pend_long_q;
  assign pend_long_d = (pend_long_q & ~clr_long) | long_rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= '0;
      pend_long_q <= '0;
      long_q      <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) hold_q[i] <= hold_d[i];
      pend_long_q <= pend_long_d;
      long_q      <= long_d;
    end
  end

  assign evt_long  = long_q;
  // A new set on a bit being granted this edge is a fresh event, not a drop
  assign overrun_d = |(rise & pend_q & ~clr_press) | |(long_rise & pend_long_q & ~clr_long);
`else
  // LONG_TICKS only matters with long-press support compiled in
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_TICKS > 0);

  assign req       = pend_q;
  assign evt_long  = 1'b0;
  assign overrun_d = |(rise & pend_q & ~clr_press);
`endif

  // Round-robin search starting just after the last granted button
  always_comb begin
    found = 1'b0;
    gnt   = '0;
    cand  = '0;
    for (int k = 1; k <= N_BTN; k++) begin
      cand = IW'((int'(last_q) + k) % N_BTN);
      if (!found && req[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  // Output slot
  always_comb begin
    valid_d   = valid_q;
    id_d      = id_q;
    last_d    = last_q;
    clr_press = '0;
`ifdef LONGPRESS_EN
    long_d    = long_q;
    clr_long  = '0;
`endif
    if (!valid_q || evt_ready) begin
      if (found) begin
        valid_d = 1'b1;
        id_d    = gnt;
        last_d  = gnt;
`ifdef LONGPRESS_EN
        // Press event is served before the long event of the same button
        if (pend_q[gnt]) begin
          clr_press[gnt] = 1'b1;
          long_d         = 1'b0;
        end else begin
          clr_long[gnt]  = 1'b1;
          long_d         = 1'b1;
        end
`else
        clr_press[gnt] = 1'b1;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  assign pend_d = (pend_q & ~clr_press) | rise;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= '0;
      state_q   <= '0;
      pend_q    <= '0;
      valid_q   <= 1'b0;
      id_q      <= '0;
      last_q    <= IW'(N_BTN - 1);
      overrun_q <= 1'b0;
    end else begin
      for (int i = 0; i < N_BTN; i++) cnt_q[i] <= cnt_d[i];
      state_q   <= state_d;
      pend_q    <= pend_d;
      valid_q   <= valid_d;
      id_q      <= id_d;
      last_q    <= last_d;
      overrun_q <= overrun_d;
    end
  end

  assign btn_state = state_q;
  assign evt_valid = valid_q;
  assign evt_id    = id_q;
  assign overrun   = overrun_q;

endmodule
